// File: rtl/rv_pkg.sv
// Shared register-file widths and writeback source encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        SRC_DBG = 2'd0,
        SRC_ALU = 2'd1,
        SRC_LSU = 2'd2
    } src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with two combinational query ports.
// Latency: set/clear/flush take effect at the next edge; queries are combinational with no bypass.
// Backpressure: none; every set/clear/flush request is applied in the cycle it is presented.
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          flush,
    input  logic [AW-1:0] query_rs1,
    input  logic [AW-1:0] query_rs2,
    output logic          busy_rs1,
    output logic          busy_rs2
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Next busy vector: commit clear, then flush, then issue set so a same-cycle set always survives.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        if (set_en && (set_idx != '0)) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy bits register; all clear out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_rs1 = busy[query_rs1];
    assign busy_rs2 = busy[query_rs2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates debug/ALU/LSU writebacks onto the single register-file write port and tracks pending writes.
// Latency: 1 cycle from grant to rf_we/rf_waddr/rf_wdata; the register file commits one edge later.
// Backpressure: ready is combinational from valids; debug has priority, ALU/LSU alternate round-robin under contention.
module rf_write_arbiter
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dbg_valid,
    input  logic [AW-1:0]   dbg_rd,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_ready,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    input  logic [AW-1:0]   query_rs1,
    input  logic [AW-1:0]   query_rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    // rr=0 prefers the ALU, rr=1 prefers the LSU when both request together.
    logic            rr;
    logic            grant_any;
    src_e            grant_src;
    logic [AW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    // Registered write came from debug; such writes must not retire scoreboard entries.
    logic            wr_dbg;

    // Pick at most one winner: debug first, then the single ALU/LSU requester or the rr-preferred one.
    always_comb begin
        dbg_ready  = 1'b0;
        alu_ready  = 1'b0;
        lsu_ready  = 1'b0;
        grant_any  = 1'b0;
        grant_src  = SRC_ALU;
        grant_rd   = '0;
        grant_data = '0;
        if (dbg_valid) begin
            dbg_ready  = 1'b1;
            grant_any  = 1'b1;
            grant_src  = SRC_DBG;
            grant_rd   = dbg_rd;
            grant_data = dbg_data;
        end else if (alu_valid && (!lsu_valid || !rr)) begin
            alu_ready  = 1'b1;
            grant_any  = 1'b1;
            grant_src  = SRC_ALU;
            grant_rd   = alu_rd;
            grant_data = alu_data;
        end else if (lsu_valid) begin
            lsu_ready  = 1'b1;
            grant_any  = 1'b1;
            grant_src  = SRC_LSU;
            grant_rd   = lsu_rd;
            grant_data = lsu_data;
        end
    end

    // Round-robin pointer flips toward whichever of ALU/LSU did not just win; debug grants leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (grant_any && (grant_src == SRC_ALU)) begin
            rr <= 1'b1;
        end else if (grant_any && (grant_src == SRC_LSU)) begin
            rr <= 1'b0;
        end
    end

    // Output register: load the winning write; x0 writes are accepted but leave rf_we low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_dbg   <= 1'b0;
        end else if (grant_any) begin
            rf_we    <= (grant_rd != '0);
            rf_waddr <= grant_rd;
            rf_wdata <= grant_data;
            wr_dbg   <= (grant_src == SRC_DBG);
        end else begin
            rf_we    <= 1'b0;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (issue_valid),
        .set_idx   (issue_rd),
        .clr_en    (rf_we && !wr_dbg),
        .clr_idx   (rf_waddr),
        .flush     (flush),
        .query_rs1 (query_rs1),
        .query_rs2 (query_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2)
    );

endmodule
